// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared constants, state encoding and feedback helper for the
//                15-bit x^15+x^14+1 additive scrambler/descrambler pair.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam int              LFSR_W       = 15;
    localparam int              TAP_A        = 14;
    localparam int              TAP_B        = 13;
    localparam logic [14:0]     DEFAULT_SEED = 15'h00A9;

    // Descrambler synchronisation states
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Keystream / feedback bit of the polynomial x^15 + x^14 + 1
    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] q);
        return q[TAP_A] ^ q[TAP_B];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr15_core.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr15_core
//  Description : 15-bit Fibonacci LFSR. Shifts left; the new LSB is either the
//                polynomial feedback (free-run) or an external bit (used to
//                load the register from a received keystream).
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr15_core
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sel_ext,
    input  logic              ext_bit,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q,
    output logic              fb
);

    logic [LFSR_W-1:0] r_q;
    logic              w_shift_in;

    assign fb         = lfsr_fb(r_q);
    assign w_shift_in = sel_ext ? ext_bit : fb;
    assign q          = r_q;

    // Shift register: seed on reset, advance only when enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= seed;
        end else if (enable) begin
            r_q <= {r_q[LFSR_W-2:0], w_shift_in};
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_descrambler.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_descrambler
//  Description : Serial additive descrambler for x^15+x^14+1. Either starts
//                seed-aligned with the scrambler (LOCKED out of reset) or
//                self-acquires from an all-zero training run
//                (HUNT -> VERIFY -> LOCKED).
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_descrambler
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED         = DEFAULT_SEED,
    parameter bit                START_LOCKED = 1'b1,
    parameter int                VERIFY_LEN   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_data,
    input  logic              resync,
    output logic              out_valid,
    output logic              out_data,
    output logic              locked,
    output logic [LFSR_W-1:0] lfsr_out,
    output logic [7:0]        slip_count
);

    localparam state_t     c_RESET_STATE = START_LOCKED ? LOCKED : HUNT;
    localparam logic [7:0] c_HUNT_LAST   = 8'(LFSR_W - 1);
    localparam logic [7:0] c_VERIFY_LAST = 8'(VERIFY_LEN - 1);

    state_t            r_state;
    logic [7:0]        r_count;
    logic [7:0]        r_slip;
    logic              r_out_valid;
    logic              r_out_data;
    logic              r_locked;

    logic [LFSR_W-1:0] w_q;
    logic              w_p;
    logic              w_advance;
    logic              w_sel_ext;

    // A resync cycle discards its bit, so the LFSR only moves on clean input
    assign w_advance = in_valid & ~resync;
    // In HUNT the payload is assumed zero, so the received bit is keystream
    assign w_sel_ext = (r_state == HUNT);

    lfsr15_core u_core (
        .clk     (clk),
        .reset   (reset),
        .enable  (w_advance),
        .sel_ext (w_sel_ext),
        .ext_bit (in_data),
        .seed    (SEED),
        .q       (w_q),
        .fb      (w_p)
    );

    // Sync state machine, bit counter, slip counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_RESET_STATE;
            r_count     <= 8'd0;
            r_slip      <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 1'b0;
            r_locked    <= START_LOCKED;
        end else if (resync) begin
            r_state     <= HUNT;
            r_count     <= 8'd0;
            r_out_valid <= 1'b0;
            r_locked    <= 1'b0;
        end else if (!in_valid) begin
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                HUNT: begin
                    r_out_valid <= 1'b0;
                    if (r_count == c_HUNT_LAST) begin
                        r_count <= 8'd0;
                        r_state <= VERIFY;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                VERIFY: begin
                    r_out_valid <= 1'b0;
                    if (in_data == w_p) begin
                        if (r_count == c_VERIFY_LAST) begin
                            r_count  <= 8'd0;
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                        end else begin
                            r_count <= r_count + 8'd1;
                        end
                    end else begin
                        r_count <= 8'd0;
                        r_state <= HUNT;
                        if (r_slip != 8'hFF) begin
                            r_slip <= r_slip + 8'd1;
                        end
                    end
                end
                LOCKED: begin
                    r_out_data  <= in_data ^ w_p;
                    r_out_valid <= 1'b1;
                end
                default: begin
                    r_state     <= HUNT;
                    r_count     <= 8'd0;
                    r_out_valid <= 1'b0;
                    r_locked    <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign locked     = r_locked;
    assign lfsr_out   = w_q;
    assign slip_count = r_slip;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_descrambler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_descrambler
//  Description : Directed self-checking bench. Two descramblers share the
//                stimulus: dut_l starts LOCKED, dut_h starts in HUNT. A
//                behavioural scrambler (state s_q) produces the link bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_descrambler;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_data;
    logic        resync;

    logic        l_out_valid, l_out_data, l_locked;
    logic [14:0] l_lfsr;
    logic [7:0]  l_slip;
    logic        h_out_valid, h_out_data, h_locked;
    logic [14:0] h_lfsr;
    logic [7:0]  h_slip;

    logic [14:0] s_q;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    lfsr_descrambler #(.SEED(15'h00A9), .START_LOCKED(1'b1), .VERIFY_LEN(32)) dut_l (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .resync(resync),
        .out_valid(l_out_valid), .out_data(l_out_data), .locked(l_locked),
        .lfsr_out(l_lfsr), .slip_count(l_slip)
    );

    lfsr_descrambler #(.SEED(15'h00A9), .START_LOCKED(1'b0), .VERIFY_LEN(32)) dut_h (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .resync(resync),
        .out_valid(h_out_valid), .out_data(h_out_data), .locked(h_locked),
        .lfsr_out(h_lfsr), .slip_count(h_slip)
    );

    function automatic logic ks(input logic [14:0] s);
        return s[14] ^ s[13];
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic v, input logic d, input logic r);
        in_valid = v;
        in_data  = d;
        resync   = r;
        @(posedge clk);
        #1;
    endtask

    // Scramble one payload bit with the model and send it
    task automatic send(input logic payload, input logic flip);
        logic sc;
        sc  = payload ^ ks(s_q) ^ flip;
        s_q = {s_q[13:0], ks(s_q)};
        step(1'b1, sc, 1'b0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 1'b0;
        resync   = 1'b0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        in_data  = 1'b0;
        resync   = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({l_lfsr, l_locked, l_out_valid, l_out_data, l_slip} !== {15'h00A9, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_l: lfsr=%h lk=%b ov=%b od=%b slip=%0d, want lfsr=00a9 lk=1 ov=0 od=0 slip=0",
                     l_lfsr, l_locked, l_out_valid, l_out_data, l_slip);
        end
        n_checks++;
        if ({h_lfsr, h_locked, h_out_valid, h_out_data, h_slip} !== {15'h00A9, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_h: lfsr=%h lk=%b ov=%b od=%b slip=%0d, want lfsr=00a9 lk=0 ov=0 od=0 slip=0",
                     h_lfsr, h_locked, h_out_valid, h_out_data, h_slip);
        end
        reset = 1'b0;
    endtask

    // Zero input: output is the raw keystream from seed 00A9
    task automatic test_keystream();
        logic exp_ks [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0, 1'b0);
            n_checks++;
            if ({l_out_valid, l_out_data, l_locked} !== {1'b1, exp_ks[i], 1'b1}) begin
                n_fail++;
                $display("FAIL keystream bit %0d: ov/od/lk=%b%b%b want 1%b1",
                         i, l_out_valid, l_out_data, l_locked, exp_ks[i]);
            end
        end
    endtask

    task automatic test_loopback();
        logic p;
        do_reset();
        s_q = 15'h00A9;
        for (int i = 0; i < 1000; i++) begin
            p = 1'($urandom_range(0, 1));
            send(p, 1'b0);
            n_checks++;
            if ({l_out_valid, l_out_data, l_locked, l_lfsr} !== {1'b1, p, 1'b1, s_q}) begin
                n_fail++;
                $display("FAIL loopback bit %0d: ov=%b od=%b lk=%b lfsr=%h want ov=1 od=%b lk=1 lfsr=%h",
                         i, l_out_valid, l_out_data, l_locked, l_lfsr, p, s_q);
            end
        end
    endtask

    task automatic test_acquisition();
        logic p;
        do_reset();
        s_q = 15'h00A9;
        repeat (100) s_q = {s_q[13:0], ks(s_q)};
        for (int n = 1; n <= 47; n++) begin
            send(1'b0, 1'b0);
            n_checks++;
            if ({h_locked, h_out_valid} !== {(n == 47), 1'b0}) begin
                n_fail++;
                $display("FAIL acquire after %0d bits: locked=%b ov=%b want locked=%b ov=0",
                         n, h_locked, h_out_valid, (n == 47));
            end
        end
        for (int i = 0; i < 200; i++) begin
            p = 1'($urandom_range(0, 1));
            send(p, 1'b0);
            n_checks++;
            if ({h_out_valid, h_out_data, h_locked, h_lfsr} !== {1'b1, p, 1'b1, s_q}) begin
                n_fail++;
                $display("FAIL acquired payload %0d: ov=%b od=%b lk=%b lfsr=%h want ov=1 od=%b lk=1 lfsr=%h",
                         i, h_out_valid, h_out_data, h_locked, h_lfsr, p, s_q);
            end
        end
    endtask

    task automatic test_verify_fail();
        logic p;
        do_reset();
        s_q = 15'h00A9;
        repeat (37) s_q = {s_q[13:0], ks(s_q)};
        repeat (15 + 10) send(1'b0, 1'b0);
        send(1'b0, 1'b1);
        n_checks++;
        if ({h_locked, h_slip, h_out_valid} !== {1'b0, 8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL verify_slip: locked=%b slip=%0d ov=%b want locked=0 slip=1 ov=0",
                     h_locked, h_slip, h_out_valid);
        end
        for (int n = 1; n <= 47; n++) begin
            send(1'b0, 1'b0);
            n_checks++;
            if (h_locked !== (n == 47)) begin
                n_fail++;
                $display("FAIL reacquire after %0d bits: locked=%b want %b", n, h_locked, (n == 47));
            end
        end
        for (int i = 0; i < 5; i++) begin
            p = 1'($urandom_range(0, 1));
            send(p, 1'b0);
            n_checks++;
            if ({h_out_valid, h_out_data, h_slip} !== {1'b1, p, 8'd1}) begin
                n_fail++;
                $display("FAIL post_reacquire %0d: ov=%b od=%b slip=%0d want ov=1 od=%b slip=1",
                         i, h_out_valid, h_out_data, h_slip, p);
            end
        end
    endtask

    // Reset asserted mid-cycle while both instances stream; checked before the next edge
    task automatic test_async_reset();
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({l_lfsr, l_out_valid, l_slip, l_locked} !== {15'h00A9, 1'b0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset_l: lfsr=%h ov=%b slip=%0d lk=%b want 00a9 0 0 1",
                     l_lfsr, l_out_valid, l_slip, l_locked);
        end
        n_checks++;
        if ({h_lfsr, h_out_valid, h_slip, h_locked} !== {15'h00A9, 1'b0, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset_h: lfsr=%h ov=%b slip=%0d lk=%b want 00a9 0 0 0",
                     h_lfsr, h_out_valid, h_slip, h_locked);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_gaps_resync();
        logic p;
        logic last_p;
        do_reset();
        s_q    = 15'h00A9;
        last_p = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                p = 1'($urandom_range(0, 1));
                send(p, 1'b0);
                last_p = p;
                n_checks++;
                if ({l_out_valid, l_out_data, l_lfsr} !== {1'b1, p, s_q}) begin
                    n_fail++;
                    $display("FAIL gap_data %0d: ov=%b od=%b lfsr=%h want ov=1 od=%b lfsr=%h",
                             i, l_out_valid, l_out_data, l_lfsr, p, s_q);
                end
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                n_checks++;
                if ({l_out_valid, l_out_data, l_lfsr} !== {1'b0, last_p, s_q}) begin
                    n_fail++;
                    $display("FAIL gap_hold %0d: ov=%b od=%b lfsr=%h want ov=0 od=%b lfsr=%h",
                             i, l_out_valid, l_out_data, l_lfsr, last_p, s_q);
                end
            end
        end
        step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        n_checks++;
        if ({l_out_valid, l_locked, l_lfsr} !== {1'b0, 1'b0, s_q}) begin
            n_fail++;
            $display("FAIL resync: ov=%b lk=%b lfsr=%h want ov=0 lk=0 lfsr=%h",
                     l_out_valid, l_locked, l_lfsr, s_q);
        end
        send(1'b0, 1'b0);
        n_checks++;
        if ({l_out_valid, l_locked} !== {1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL post_resync_hunt: ov=%b lk=%b want ov=0 lk=0", l_out_valid, l_locked);
        end
    endtask

    initial begin
        test_reset();
        test_keystream();
        test_loopback();
        test_acquisition();
        test_verify_fail();
        test_async_reset();
        test_gaps_resync();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete within time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
